draw_arbiter: RTL and testbench

Parametrised arbiter that serialises framebuffer writes from NUM_CLIENTS independent draw engines (cell drawer, cursor drawer, future overlays) onto a single registered pixel write port. It sits between the draw engines and the video memory write side, replacing the fixed two-way cell/cursor select. It adds fixed-priority or round-robin arbitration, a request/grant burst handshake, per-burst pixel counting and a burst watchdog.

---
 rtl/draw_arbiter_if.sv | 43 ++++
 rtl/draw_arbiter.sv | 136 +++++++++++++
 tb/tb_draw_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/draw_arbiter_if.sv
// Draw-client to framebuffer arbitration bundle: client requests and pixels in, grant and write port out.
// Latency: none (wiring only).
// Backpressure: none of its own; grant is the only flow control seen by the draw engines.
interface draw_arbiter_if #(
    parameter int NUM_CLIENTS = 2,
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int COLOR_W     = 3,
    parameter int MAX_BURST   = 4096
);
    localparam int OWN_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    // client side
    logic [NUM_CLIENTS-1:0]         req;
    logic [NUM_CLIENTS-1:0]         pix_valid;
    logic [NUM_CLIENTS-1:0]         pix_last;
    logic [NUM_CLIENTS*X_W-1:0]     pix_x;
    logic [NUM_CLIENTS*Y_W-1:0]     pix_y;
    logic [NUM_CLIENTS*COLOR_W-1:0] pix_color;
    logic                           err_clr;

    // arbiter side
    logic [NUM_CLIENTS-1:0]         grant;
    logic                           fb_we;
    logic [X_W-1:0]                 fb_x;
    logic [Y_W-1:0]                 fb_y;
    logic [COLOR_W-1:0]             fb_color;
    logic                           busy;
    logic [OWN_W-1:0]               owner;
    logic [CNT_W-1:0]               pix_count;
    logic                           timeout_err;

    modport master (
        output req, pix_valid, pix_last, pix_x, pix_y, pix_color, err_clr,
        input  grant, fb_we, fb_x, fb_y, fb_color, busy, owner, pix_count, timeout_err
    );

    modport slave (
        input  req, pix_valid, pix_last, pix_x, pix_y, pix_color, err_clr,
        output grant, fb_we, fb_x, fb_y, fb_color, busy, owner, pix_count, timeout_err
    );
endinterface

// File: rtl/draw_arbiter.sv
// Serialises bursts from NUM_CLIENTS draw engines onto one registered framebuffer write port.
// Latency: grant 1 cycle after req in IDLE; pixel reaches fb_* 1 cycle after pix_valid.
// Backpressure: none per pixel; ungranted clients wait on grant, a stuck burst is cut by the watchdog.
module draw_arbiter #(
    parameter int NUM_CLIENTS = 2,
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int COLOR_W     = 3,
    parameter int RR_MODE     = 0,
    parameter int MAX_BURST   = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    draw_arbiter_if.slave bus
);
    localparam int OWN_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int WD_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(MAX_BURST - 1);
    localparam logic [OWN_W-1:0] PTR_RST = OWN_W'(NUM_CLIENTS - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                 state_q, state_d;
    logic [OWN_W-1:0]       owner_q;
    logic [OWN_W-1:0]       rr_ptr_q;
    logic [WD_W-1:0]        wd_cnt_q;

    int                     cand;
    logic                   win_vld;
    logic [OWN_W-1:0]       win_idx;
    logic [NUM_CLIENTS-1:0] win_oh;

    logic                   fwd;
    logic                   end_last;
    logic                   end_abort;
    logic                   end_wd;
    logic                   burst_end;
    logic                   set_err;

    assign bus.owner = owner_q;

    // Winner search: from index 0 in fixed priority, from rr_ptr+1 with wrap in round-robin.
    always_comb begin
        cand    = 0;
        win_vld = 1'b0;
        win_idx = '0;
        win_oh  = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            cand = (RR_MODE != 0) ? ((int'(rr_ptr_q) + 1 + i) % NUM_CLIENTS) : i;
            if (!win_vld && bus.req[cand]) begin
                win_vld      = 1'b1;
                win_idx      = OWN_W'(cand);
                win_oh[cand] = 1'b1;
            end
        end
    end

    // Burst events for the granted client; an ungranted client's pixels never reach fwd.
    always_comb begin
        fwd       = (state_q == BURST) && bus.pix_valid[owner_q];
        end_last  = fwd && bus.pix_last[owner_q];
        end_abort = (state_q == BURST) && !bus.req[owner_q];
        end_wd    = (state_q == BURST) && (wd_cnt_q == WD_LAST);
        burst_end = end_last || end_abort || end_wd;
        // a normal end or a clean abort on the watchdog cycle is not an error
        set_err   = end_wd && !end_last && !end_abort;
    end

    // Next-state logic: every burst exit passes through IDLE before the next grant.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_vld)   state_d = BURST;
            BURST:   if (burst_end) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Grant, pixel forwarding, counters and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.grant       <= '0;
            bus.busy        <= 1'b0;
            bus.fb_we       <= 1'b0;
            bus.fb_x        <= '0;
            bus.fb_y        <= '0;
            bus.fb_color    <= '0;
            bus.pix_count   <= '0;
            bus.timeout_err <= 1'b0;
            owner_q         <= '0;
            rr_ptr_q        <= PTR_RST;
            wd_cnt_q        <= '0;
        end else begin
            bus.fb_we <= fwd;
            if (fwd) begin
                bus.fb_x     <= bus.pix_x[owner_q*X_W +: X_W];
                bus.fb_y     <= bus.pix_y[owner_q*Y_W +: Y_W];
                bus.fb_color <= bus.pix_color[owner_q*COLOR_W +: COLOR_W];
            end

            if (state_q == IDLE) begin
                wd_cnt_q <= '0;
                if (win_vld) begin
                    bus.grant     <= win_oh;
                    bus.busy      <= 1'b1;
                    bus.pix_count <= '0;
                    owner_q       <= win_idx;
                    rr_ptr_q      <= win_idx;
                end
            end else begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
                if (fwd && (bus.pix_count != CNT_MAX))
                    bus.pix_count <= bus.pix_count + 1'b1;
                if (burst_end) begin
                    bus.grant <= '0;
                    bus.busy  <= 1'b0;
                end
            end

            // set wins over a simultaneous clear
            if (set_err)
                bus.timeout_err <= 1'b1;
            else if (bus.err_clr)
                bus.timeout_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_draw_arbiter.sv
// Directed bench: two arbiter instances (2-client fixed priority, 4-client round-robin), MAX_BURST=8.
// Latency: outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure: clients follow the req/grant handshake; stuck bursts exercise the watchdog.
module tb_draw_arbiter;
    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    draw_arbiter_if #(.NUM_CLIENTS(2), .X_W(10), .Y_W(9), .COLOR_W(3), .MAX_BURST(8)) bus0();
    draw_arbiter_if #(.NUM_CLIENTS(4), .X_W(10), .Y_W(9), .COLOR_W(3), .MAX_BURST(8)) bus1();

    draw_arbiter #(.NUM_CLIENTS(2), .X_W(10), .Y_W(9), .COLOR_W(3), .RR_MODE(0), .MAX_BURST(8))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    draw_arbiter #(.NUM_CLIENTS(4), .X_W(10), .Y_W(9), .COLOR_W(3), .RR_MODE(1), .MAX_BURST(8))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus0.req = '0; bus0.pix_valid = '0; bus0.pix_last = '0;
        bus0.pix_x = '0; bus0.pix_y = '0; bus0.pix_color = '0; bus0.err_clr = 1'b0;
        bus1.req = '0; bus1.pix_valid = '0; bus1.pix_last = '0;
        bus1.pix_x = '0; bus1.pix_y = '0; bus1.pix_color = '0; bus1.err_clr = 1'b0;
    endtask

    logic [3:0] rr_exp [0:8];

    initial begin
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0000; rr_exp[2] = 4'b0010;
        rr_exp[3] = 4'b0000; rr_exp[4] = 4'b0100; rr_exp[5] = 4'b0000;
        rr_exp[6] = 4'b1000; rr_exp[7] = 4'b0000; rr_exp[8] = 4'b0001;

        rst_n = 1'b0;
        clear_inputs();
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // reset state
        chk("rst_grant", 32'(bus0.grant), 32'h0);
        chk("rst_busy", 32'(bus0.busy), 32'h0);
        chk("rst_owner", 32'(bus0.owner), 32'h0);
        chk("rst_fb_we", 32'(bus0.fb_we), 32'h0);
        chk("rst_count", 32'(bus0.pix_count), 32'h0);
        chk("rst_terr", 32'(bus0.timeout_err), 32'h0);

        // single client burst of three pixels
        bus0.req[1] = 1'b1;
        step();
        chk("t1_grant", 32'(bus0.grant), 32'h2);
        chk("t1_busy", 32'(bus0.busy), 32'h1);
        chk("t1_owner", 32'(bus0.owner), 32'h1);
        bus0.pix_valid[1] = 1'b1;
        bus0.pix_x[10 +: 10] = 10'd10;
        bus0.pix_y[9 +: 9] = 9'd20;
        bus0.pix_color[3 +: 3] = 3'd5;
        step();
        chk("t1_we0", 32'(bus0.fb_we), 32'h1);
        chk("t1_x0", 32'(bus0.fb_x), 32'd10);
        chk("t1_y0", 32'(bus0.fb_y), 32'd20);
        chk("t1_c0", 32'(bus0.fb_color), 32'd5);
        bus0.pix_x[10 +: 10] = 10'd11;
        step();
        chk("t1_we1", 32'(bus0.fb_we), 32'h1);
        chk("t1_x1", 32'(bus0.fb_x), 32'd11);
        bus0.pix_x[10 +: 10] = 10'd12;
        bus0.pix_last[1] = 1'b1;
        step();
        chk("t1_we2", 32'(bus0.fb_we), 32'h1);
        chk("t1_x2", 32'(bus0.fb_x), 32'd12);
        chk("t1_grant_drop", 32'(bus0.grant), 32'h0);
        chk("t1_busy_drop", 32'(bus0.busy), 32'h0);
        chk("t1_count", 32'(bus0.pix_count), 32'd3);
        clear_inputs();
        step();
        chk("t1_we_off", 32'(bus0.fb_we), 32'h0);
        chk("t1_x_hold", 32'(bus0.fb_x), 32'd12);

        // fixed priority: client 0 always wins, one idle cycle between bursts
        bus0.req = 2'b11;
        bus0.pix_valid = 2'b11;
        bus0.pix_last = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fp_grant_on", 32'(bus0.grant), 32'h1);
            step();
            chk("fp_grant_idle", 32'(bus0.grant), 32'h0);
            chk("fp_we", 32'(bus0.fb_we), 32'h1);
        end
        clear_inputs();
        step();

        // round-robin on the 4-client instance
        bus1.req = 4'b1111;
        bus1.pix_valid = 4'b1111;
        bus1.pix_last = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("rr_grant", 32'(bus1.grant), 32'(rr_exp[i]));
        end
        clear_inputs();
        step();
        chk("rr_release", 32'(bus1.grant), 32'h0);

        // watchdog expiry with no last
        bus0.req = 2'b01;
        bus0.pix_valid = 2'b01;
        step();
        chk("wd_grant", 32'(bus0.grant), 32'h1);
        repeat (7) step();
        chk("wd_still_held", 32'(bus0.grant), 32'h1);
        chk("wd_no_err_yet", 32'(bus0.timeout_err), 32'h0);
        step();
        chk("wd_release", 32'(bus0.grant), 32'h0);
        chk("wd_err", 32'(bus0.timeout_err), 32'h1);
        chk("wd_count", 32'(bus0.pix_count), 32'd8);
        clear_inputs();
        step();
        chk("wd_err_sticky", 32'(bus0.timeout_err), 32'h1);
        bus0.err_clr = 1'b1;
        step();
        bus0.err_clr = 1'b0;
        chk("wd_err_clr", 32'(bus0.timeout_err), 32'h0);

        // last on the watchdog cycle is a normal end
        bus0.req = 2'b01;
        bus0.pix_valid = 2'b01;
        step();
        repeat (7) step();
        bus0.pix_last = 2'b01;
        step();
        chk("wdl_release", 32'(bus0.grant), 32'h0);
        chk("wdl_no_err", 32'(bus0.timeout_err), 32'h0);
        chk("wdl_we", 32'(bus0.fb_we), 32'h1);
        chk("wdl_count", 32'(bus0.pix_count), 32'd8);
        clear_inputs();
        step();

        // abort by client 0 while client 1 toggles pix_valid
        bus0.req = 2'b01;
        step();
        chk("ab_grant", 32'(bus0.grant), 32'h1);
        for (int i = 0; i < 3; i++) begin
            bus0.pix_valid[1] = ~bus0.pix_valid[1];
            bus0.pix_x[10 +: 10] = 10'(100 + i);
            step();
            chk("ab_iso_we", 32'(bus0.fb_we), 32'h0);
        end
        bus0.req = 2'b00;
        step();
        chk("ab_grant_drop", 32'(bus0.grant), 32'h0);
        chk("ab_busy", 32'(bus0.busy), 32'h0);
        chk("ab_no_err", 32'(bus0.timeout_err), 32'h0);
        chk("ab_we", 32'(bus0.fb_we), 32'h0);
        chk("ab_count", 32'(bus0.pix_count), 32'd0);
        clear_inputs();
        step();

        // asynchronous reset in the middle of a pixel stream
        bus0.req = 2'b10;
        step();
        bus0.pix_valid = 2'b10;
        bus0.pix_x[10 +: 10] = 10'd100;
        bus0.pix_y[9 +: 9] = 9'd7;
        bus0.pix_color[3 +: 3] = 3'd3;
        step();
        chk("mr_we_before", 32'(bus0.fb_we), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_grant", 32'(bus0.grant), 32'h0);
        chk("mr_we", 32'(bus0.fb_we), 32'h0);
        chk("mr_x", 32'(bus0.fb_x), 32'h0);
        chk("mr_y", 32'(bus0.fb_y), 32'h0);
        chk("mr_color", 32'(bus0.fb_color), 32'h0);
        chk("mr_busy", 32'(bus0.busy), 32'h0);
        chk("mr_owner", 32'(bus0.owner), 32'h0);
        chk("mr_count", 32'(bus0.pix_count), 32'h0);
        chk("mr_rr_owner", 32'(bus1.owner), 32'h0);
        bus0.pix_valid = 2'b00;
        rst_n = 1'b1;
        step();
        chk("mr_regrant", 32'(bus0.grant), 32'h2);
        bus0.pix_valid = 2'b10;
        bus0.pix_last = 2'b10;
        bus0.pix_x[10 +: 10] = 10'd7;
        step();
        chk("mr_restart_we", 32'(bus0.fb_we), 32'h1);
        chk("mr_restart_x", 32'(bus0.fb_x), 32'd7);
        chk("mr_restart_drop", 32'(bus0.grant), 32'h0);
        chk("mr_restart_count", 32'(bus0.pix_count), 32'd1);

        // round-robin pointer restarts at client 0 after reset
        clear_inputs();
        bus1.req = 4'b1111;
        step();
        chk("mr_rr_first", 32'(bus1.grant), 32'h1);
        clear_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
